// File: rtl/cls_line_update_seq_if.sv
`timescale 1ns/1ps
// Request and CLS-driver handshake bundle for cls_line_update_seq.
// The slave modport is the sequencer; the master modport is whatever
// issues update requests and plays the CLS driver.
interface cls_line_update_seq_if;
  logic         i_update_req;
  logic         i_force;
  logic [127:0] i_dat_ascii_line1;
  logic [127:0] i_dat_ascii_line2;
  logic         o_update_busy;
  logic         o_update_done;
  logic         i_command_ready;
  logic         o_cmd_wr_clear_display;
  logic         o_cmd_wr_text_line1;
  logic         o_cmd_wr_text_line2;
  logic [127:0] o_dat_ascii_line1;
  logic [127:0] o_dat_ascii_line2;

  modport slave (
    input  i_update_req, i_force, i_dat_ascii_line1, i_dat_ascii_line2, i_command_ready,
    output o_update_busy, o_update_done, o_cmd_wr_clear_display, o_cmd_wr_text_line1,
           o_cmd_wr_text_line2, o_dat_ascii_line1, o_dat_ascii_line2
  );

  modport master (
    output i_update_req, i_force, i_dat_ascii_line1, i_dat_ascii_line2, i_command_ready,
    input  o_update_busy, o_update_done, o_cmd_wr_clear_display, o_cmd_wr_text_line1,
           o_cmd_wr_text_line2, o_dat_ascii_line1, o_dat_ascii_line2
  );
endinterface

// File: rtl/cls_line_update_seq.sv
`timescale 1ns/1ps
// cls_line_update_seq: on request or periodic refresh, latches two lines of
// text and issues clear / line1 / line2 write commands to a CLS driver,
// skipping the writes when the text is unchanged and the update is unforced.
module cls_line_update_seq #(
  parameter int parm_fast_simulation = 0,
  parameter int FCLK_ce              = 2500000,
  parameter int parm_refresh_ms      = 500,
  parameter int parm_clear_first     = 1
) (
  input  logic                 i_clk_20mhz,
  input  logic                 i_rst_20mhz,
  input  logic                 i_ce_2_5mhz,
  cls_line_update_seq_if.slave io_bus
);

  // Refresh period in ce ticks minus one; 64-bit math keeps the product exact.
  localparam longint C_TICKS_FULL = (longint'(FCLK_ce) * longint'(parm_refresh_ms)) / 64'sd1000;
  localparam longint C_RELOAD     = (parm_fast_simulation != 0) ? 64'sd15 :
                                    ((C_TICKS_FULL > 64'sd0) ? (C_TICKS_FULL - 64'sd1) : 64'sd0);
  localparam bit     C_REFRESH_EN = (parm_fast_simulation != 0) || (parm_refresh_ms != 0);
  localparam int     C_TW         = (C_RELOAD < 64'sd2) ? 1 : $clog2(C_RELOAD + 64'sd1);
  localparam logic [C_TW-1:0] C_RELOAD_V = C_TW'(C_RELOAD);
  localparam logic [C_TW-1:0] C_ONE      = C_TW'(1'b1);
  localparam logic [C_TW-1:0] C_ZERO     = C_TW'(1'b0);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LATCH    = 4'd1,
    ST_CLR_CMD  = 4'd2,
    ST_CLR_WAIT = 4'd3,
    ST_L1_CMD   = 4'd4,
    ST_L1_WAIT  = 4'd5,
    ST_L2_CMD   = 4'd6,
    ST_L2_WAIT  = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_pend;
  logic            r_pend_force;
  logic            r_force_lat;
  logic [C_TW-1:0] r_timer;
  logic            r_busy;
  logic            r_done;
  logic            r_cmd_clr;
  logic            r_cmd_l1;
  logic            r_cmd_l2;
  logic [127:0]    r_dat_l1;
  logic [127:0]    r_dat_l2;
  logic [127:0]    r_last_l1;
  logic [127:0]    r_last_l2;
  logic            r_last_valid;
  logic            w_cmd_clr_nxt;
  logic            w_cmd_l1_nxt;
  logic            w_cmd_l2_nxt;
  logic            w_expired;
  logic            w_enter_latch;
  logic            w_text_same;

  // A saturated timer means a refresh is due; it waits in place until IDLE.
  assign w_expired     = C_REFRESH_EN && (r_timer == C_ZERO);
  assign w_enter_latch = i_ce_2_5mhz && (r_state == ST_IDLE) && (w_state_nxt == ST_LATCH);
  assign w_text_same   = r_last_valid &&
                         (io_bus.i_dat_ascii_line1 == r_last_l1) &&
                         (io_bus.i_dat_ascii_line2 == r_last_l2);

  // Next-state and next-command decode; commands are one-hot by construction.
  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_clr_nxt = 1'b0;
    w_cmd_l1_nxt  = 1'b0;
    w_cmd_l2_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend || w_expired) w_state_nxt = ST_LATCH;
        else                     w_state_nxt = ST_IDLE;
      end
      ST_LATCH: begin
        if (w_text_same && !r_force_lat) w_state_nxt = ST_DONE;
        else if (parm_clear_first != 0)  w_state_nxt = ST_CLR_CMD;
        else                             w_state_nxt = ST_L1_CMD;
      end
      ST_CLR_CMD: begin
        if (io_bus.i_command_ready) begin
          w_state_nxt   = ST_CLR_WAIT;
          w_cmd_clr_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_CLR_CMD;
        end
      end
      ST_CLR_WAIT: begin
        if (!io_bus.i_command_ready) w_state_nxt = ST_L1_CMD;
        else                         w_state_nxt = ST_CLR_WAIT;
      end
      ST_L1_CMD: begin
        if (io_bus.i_command_ready) begin
          w_state_nxt  = ST_L1_WAIT;
          w_cmd_l1_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_L1_CMD;
        end
      end
      ST_L1_WAIT: begin
        if (!io_bus.i_command_ready) w_state_nxt = ST_L2_CMD;
        else                         w_state_nxt = ST_L1_WAIT;
      end
      ST_L2_CMD: begin
        if (io_bus.i_command_ready) begin
          w_state_nxt  = ST_L2_WAIT;
          w_cmd_l2_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_L2_CMD;
        end
      end
      ST_L2_WAIT: begin
        if (!io_bus.i_command_ready) w_state_nxt = ST_DONE;
        else                         w_state_nxt = ST_L2_WAIT;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, advanced only on ce ticks.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz)      r_state <= ST_IDLE;
    else if (i_ce_2_5mhz) r_state <= w_state_nxt;
  end

  // Sticky request flags, captured on any clock; a new request wins over the latch clear.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_pend       <= 1'b0;
      r_pend_force <= 1'b0;
    end else if (io_bus.i_update_req) begin
      r_pend       <= 1'b1;
      r_pend_force <= (w_enter_latch ? 1'b0 : r_pend_force) | io_bus.i_force;
    end else if (w_enter_latch) begin
      r_pend       <= 1'b0;
      r_pend_force <= 1'b0;
    end
  end

  // Force decision for the current sequence: requested force or refresh.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz)        r_force_lat <= 1'b0;
    else if (w_enter_latch) r_force_lat <= r_pend_force | w_expired;
  end

  // Refresh timer: counts ce ticks down to zero, reloads on every LATCH entry.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_timer <= C_RELOAD_V;
    end else if (i_ce_2_5mhz) begin
      if (w_enter_latch)          r_timer <= C_RELOAD_V;
      else if (r_timer != C_ZERO) r_timer <= r_timer - C_ONE;
    end
  end

  // Registered command strobes, each held for one full ce period.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_cmd_clr <= 1'b0;
      r_cmd_l1  <= 1'b0;
      r_cmd_l2  <= 1'b0;
    end else if (i_ce_2_5mhz) begin
      r_cmd_clr <= w_cmd_clr_nxt;
      r_cmd_l1  <= w_cmd_l1_nxt;
      r_cmd_l2  <= w_cmd_l2_nxt;
    end
  end

  // Busy covers LATCH entry through DONE exit; done pulses for one clock at DONE exit.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (i_ce_2_5mhz) r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= i_ce_2_5mhz && (r_state == ST_DONE);
    end
  end

  // Text latch, loaded once per sequence so the driver sees stable data.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_dat_l1 <= 128'h0;
      r_dat_l2 <= 128'h0;
    end else if (i_ce_2_5mhz && (r_state == ST_LATCH)) begin
      r_dat_l1 <= io_bus.i_dat_ascii_line1;
      r_dat_l2 <= io_bus.i_dat_ascii_line2;
    end
  end

  // Last-written text; invalid after reset so the first update always writes.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_last_l1    <= 128'h0;
      r_last_l2    <= 128'h0;
      r_last_valid <= 1'b0;
    end else if (i_ce_2_5mhz && (r_state == ST_DONE)) begin
      r_last_l1    <= r_dat_l1;
      r_last_l2    <= r_dat_l2;
      r_last_valid <= 1'b1;
    end
  end

  assign io_bus.o_update_busy          = r_busy;
  assign io_bus.o_update_done          = r_done;
  assign io_bus.o_cmd_wr_clear_display = r_cmd_clr;
  assign io_bus.o_cmd_wr_text_line1    = r_cmd_l1;
  assign io_bus.o_cmd_wr_text_line2    = r_cmd_l2;
  assign io_bus.o_dat_ascii_line1      = r_dat_l1;
  assign io_bus.o_dat_ascii_line2      = r_dat_l2;

endmodule

// File: doc/cls_line_update_seq.md
CLS_LINE_UPDATE_SEQ -- requirements
Module: cls_line_update_seq

Interface
REQ-001 SHALL have parameter parm_fast_simulation, default 0: when 1, the refresh period is 16 ce ticks.
REQ-002 SHALL have parameter FCLK_ce, default 2500000: frequency in Hz of i_ce_2_5mhz.
REQ-003 SHALL have parameter parm_refresh_ms, default 500: periodic refresh period in ms; 0 disables refresh.
REQ-004 SHALL have parameter parm_clear_first, default 1: when 1, issue a clear-display before the line writes.
REQ-005 SHALL use one clock with synchronous, active-high reset, ports as follows:
i_clk_20mhz  in  1  system clock.
i_rst_20mhz  in  1  synchronous active-high reset.
i_ce_2_5mhz  in  1  clock enable shared with the CLS driver.
i_update_req  in  1  one-clock pulse; request a display update.
i_force  in  1  sampled with i_update_req; write even if text is unchanged.
i_dat_ascii_line1  in  128  upstream line-1 text, 16 ASCII bytes, MSB byte first.
i_dat_ascii_line2  in  128  upstream line-2 text.
o_update_busy  out  1  high from request acceptance until ST_DONE exits.
o_update_done  out  1  one-clock pulse on completion.
i_command_ready  in  1  from the CLS driver.
o_cmd_wr_clear_display  out  1  to the CLS driver.
o_cmd_wr_text_line1  out  1  to the CLS driver.
o_cmd_wr_text_line2  out  1  to the CLS driver.
o_dat_ascii_line1  out  128  latched line 1, held stable during the sequence.
o_dat_ascii_line2  out  128  latched line 2.

Function
REQ-006 SHALL advance the FSM, timer and command outputs only on cycles with i_ce_2_5mhz=1; each command output is registered and stays high for exactly one ce period (8 clocks).
REQ-007 SHALL capture i_update_req and i_force on any clock (not only ce cycles) into the sticky flags pend and pend_force; these clear when ST_LATCH is entered.
REQ-008 SHALL implement these states: ST_IDLE, ST_LATCH, ST_CLR_CMD, ST_CLR_WAIT, ST_L1_CMD, ST_L1_WAIT, ST_L2_CMD, ST_L2_WAIT, ST_DONE.
REQ-009 ST_IDLE SHALL go to ST_LATCH when pend=1 or the refresh timer expires; refresh acts as a forced update.
REQ-010 ST_LATCH SHALL copy the inputs to o_dat_ascii_line1/2.
REQ-011 ST_LATCH SHALL go to ST_DONE without any command when the text equals the last-written text and the update is not forced.
REQ-012 ST_LATCH SHALL otherwise go to ST_CLR_CMD if parm_clear_first=1, else to ST_L1_CMD.
REQ-013 Each xx_CMD state SHALL wait for i_command_ready=1, then assert its command for one ce period and go to xx_WAIT.
REQ-014 Each xx_WAIT state SHALL wait for i_command_ready=0, which confirms acceptance, then go to the next CMD state.
REQ-015 The wait sequence SHALL be CLR to L1 to L2, and L2_WAIT to ST_DONE.
REQ-016 ST_DONE SHALL pulse o_update_done for one clock, store the latched text as last-written, and return to ST_IDLE.
REQ-017 SHALL never assert two command outputs in the same cycle.
REQ-018 SHALL keep o_dat_ascii_line1/2 unchanged from ST_LATCH until the next ST_LATCH.
REQ-019 The refresh timer SHALL be a counter of ce ticks, sized by clog2 of the reload value.
REQ-020 The timer reload value SHALL be FCLK_ce*parm_refresh_ms/1000-1, or 15 when parm_fast_simulation=1.
REQ-021 The timer SHALL reload on expiry and whenever ST_LATCH is entered.
REQ-022 A request arriving during busy SHALL set pend and be serviced exactly once after ST_DONE; multiple requests during busy SHALL merge into one.
REQ-023 When a request and a timer expiry coincide, SHALL perform one forced update.
REQ-024 The last-written text SHALL be invalid after reset, so the first update always writes.

Reset
REQ-025 On i_rst_20mhz=1 at a clock edge, independent of i_ce_2_5mhz, SHALL enter ST_IDLE.
REQ-026 On reset SHALL drive all command outputs, o_update_busy and o_update_done to 0.
REQ-027 On reset SHALL clear o_dat_ascii_line1/2 to 128'h0, clear pend, pend_force and the valid bit of last-written, and reload the timer.
REQ-028 Reset mid-sequence SHALL abort the sequence with no further command pulse issued.

Verification
REQ-029 Scenario: after reset, ready=1, pulse update_req with line1="ACL TESTER      ".
Required response: clear, line1, line2 commands, each one ce period wide, in order; then o_update_done.
REQ-030 Scenario: repeat the same text without force.
Required response: no command pulses; o_update_done within 3 ce ticks.
REQ-031 Scenario: the model holds ready=0 for 200 ce after each command.
Required response: the next command is delayed until ready=1; no overlap; exactly 3 commands.
REQ-032 Scenario: 3 update_req pulses during busy.
Required response: exactly one further sequence after the first done.
REQ-033 Scenario: parm_fast_simulation=1, no requests.
Required response: a forced refresh sequence starts every 16 ce ticks after the previous ST_LATCH.
REQ-034 Scenario: reset asserted during ST_L1_WAIT.
Required response: all outputs 0 on the next clock; o_cmd_wr_text_line2 is never asserted.
